// File: rtl/fwd_pkg.sv
// Shared types for the forwarding/hazard unit: destination tag, select and stage constants.
package fwd_pkg;

  // Tag fields are sized for the widest configuration; narrower ports are zero-extended.
  localparam int TAG_REG_W  = 8;
  localparam int TAG_RDY_W  = 4;

  localparam int FWD_SEL_RF = 0;
  localparam int STG_EX     = 0;
  localparam int STG_MEM    = 1;
  localparam int STG_WB     = 2;

  typedef struct packed {
    logic                 valid;
    logic                 wen;
    logic [TAG_REG_W-1:0] rd;
    logic [TAG_RDY_W-1:0] rdy;
  } fwd_tag_t;

  // x0 is hardwired, so a write to it never produces a usable value.
  function automatic logic tag_match(fwd_tag_t t, logic [TAG_REG_W-1:0] rs);
    return t.valid && t.wen && (t.rd != '0) && (t.rd == rs);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Youngest-match search of one source register over NT tags (index 0 = youngest).
module fwd_match
  import fwd_pkg::*;
#(
  parameter int NT = 3
)(
  input  fwd_tag_t [NT-1:0]      tags,
  input  logic [TAG_REG_W-1:0]   rs,
  input  logic                   en,
  output logic                   hit,
  output logic [TAG_RDY_W-1:0]   pos,
  output logic [TAG_RDY_W-1:0]   rdy
);

  logic [NT:0]                  h;
  logic [NT:0][TAG_RDY_W-1:0]   p;
  logic [NT:0][TAG_RDY_W-1:0]   r;

  assign h[NT] = 1'b0;
  assign p[NT] = '0;
  assign r[NT] = '0;

  // Mux chain from oldest to youngest so the lowest matching index wins.
  for (genvar i = 0; i < NT; i++) begin : g_ent
    logic m;
    assign m    = en && tag_match(tags[i], rs);
    assign h[i] = m | h[i+1];
    assign p[i] = m ? TAG_RDY_W'(i) : p[i+1];
    assign r[i] = m ? tags[i].rdy   : r[i+1];
  end

  assign hit = h[0];
  assign pos = p[0];
  assign rdy = r[0];

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use/multi-cycle hazard detection with a private tag pipeline.
// Optional FWD_HAZARD_PERF_EN adds stall-cycle and forwarded-operand counters.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int N_SRC = 2,
  parameter int DEPTH = 3,
  parameter int REG_W = 5,
  parameter int RDY_W = 2,
  parameter int SEL_W = 2
)(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   hold_i,
  input  logic                   flush_e_i,
  input  logic [REG_W-1:0]       rd_d_i,
  input  logic                   wen_d_i,
  input  logic [RDY_W-1:0]       rdy_d_i,
  input  logic [N_SRC*REG_W-1:0] rs_d_i,
  input  logic [N_SRC-1:0]       use_d_i,
  input  logic [N_SRC*REG_W-1:0] rs_e_i,
  output logic [N_SRC*SEL_W-1:0] fwd_e_o,
  output logic                   stall_fd_o,
  output logic                   bubble_e_o
`ifdef FWD_HAZARD_PERF_EN
  ,
  output logic [31:0]            perf_stall_o,
  output logic [31:0]            perf_fwd_o
`endif
);

  fwd_tag_t [DEPTH:0]               tag;
  fwd_tag_t                         dec_tag;
  logic [N_SRC-1:0]                 haz;
  logic [N_SRC-1:0][SEL_W-1:0]      fwd;

  always_comb begin
    dec_tag       = '0;
    dec_tag.valid = 1'b1;
    dec_tag.wen   = wen_d_i;
    dec_tag.rd    = TAG_REG_W'(rd_d_i);
    dec_tag.rdy   = TAG_RDY_W'(rdy_d_i);
  end

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    logic                 ex_hit, d_hit;
    logic [TAG_RDY_W-1:0] ex_pos, ex_rdy, d_pos, d_rdy, ex_stg, d_stg;

    fwd_match #(.NT(DEPTH)) u_ex (
      .tags (tag[DEPTH:STG_MEM]),
      .rs   (TAG_REG_W'(rs_e_i[g*REG_W +: REG_W])),
      .en   (1'b1),
      .hit  (ex_hit),
      .pos  (ex_pos),
      .rdy  (ex_rdy)
    );

    fwd_match #(.NT(DEPTH)) u_d (
      .tags (tag[DEPTH-1:STG_EX]),
      .rs   (TAG_REG_W'(rs_d_i[g*REG_W +: REG_W])),
      .en   (use_d_i[g]),
      .hit  (d_hit),
      .pos  (d_pos),
      .rdy  (d_rdy)
    );

    assign ex_stg = ex_pos + TAG_RDY_W'(1);
    // A tag at index s is one stage further along by the time the consumer sits in EX.
    assign d_stg  = d_pos + TAG_RDY_W'(1);

    assign fwd[g] = (ex_hit && ex_rdy <= ex_stg) ? SEL_W'(ex_stg) : SEL_W'(FWD_SEL_RF);
    assign haz[g] = d_hit && (d_rdy > d_stg);

    a_fwd_ready: assert property (@(posedge clk) disable iff (reset)
      !(ex_hit && ex_rdy > ex_stg));
  end

  assign fwd_e_o    = fwd;
  assign stall_fd_o = (|haz) & ~reset;
  assign bubble_e_o = ((|haz) | flush_e_i) & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag <= '0;
    end else if (!hold_i) begin
      tag[DEPTH:1]  <= tag[DEPTH-1:0];
      tag[STG_EX]   <= bubble_e_o ? '0 : dec_tag;
    end else if (flush_e_i) begin
      tag[STG_EX].valid <= 1'b0;
    end
  end

`ifdef FWD_HAZARD_PERF_EN
  logic [31:0] fwd_cnt;

  always_comb begin
    fwd_cnt = '0;
    for (int i = 0; i < N_SRC; i++) fwd_cnt = fwd_cnt + 32'(fwd[i] != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_o <= '0;
      perf_fwd_o   <= '0;
    end else if (!hold_i) begin
      if (stall_fd_o) perf_stall_o <= perf_stall_o + 32'd1;
      perf_fwd_o <= perf_fwd_o + fwd_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Table-driven bench for fwd_hazard_unit with a scoreboard queue of expected outputs.
module tb_fwd_hazard_unit;
  localparam int N_SRC = 2, DEPTH = 3, REG_W = 5, RDY_W = 2, SEL_W = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   hold_i, flush_e_i, wen_d_i;
  logic [REG_W-1:0]       rd_d_i;
  logic [RDY_W-1:0]       rdy_d_i;
  logic [N_SRC*REG_W-1:0] rs_d_i, rs_e_i;
  logic [N_SRC-1:0]       use_d_i;
  logic [N_SRC*SEL_W-1:0] fwd_e_o;
  logic                   stall_fd_o, bubble_e_o;
`ifdef FWD_HAZARD_PERF_EN
  logic [31:0]            perf_stall_o, perf_fwd_o;
`endif

  always #5 clk = ~clk;

  fwd_hazard_unit #(.N_SRC(N_SRC), .DEPTH(DEPTH), .REG_W(REG_W), .RDY_W(RDY_W), .SEL_W(SEL_W)) dut (
    .clk(clk), .reset(reset), .hold_i(hold_i), .flush_e_i(flush_e_i),
    .rd_d_i(rd_d_i), .wen_d_i(wen_d_i), .rdy_d_i(rdy_d_i),
    .rs_d_i(rs_d_i), .use_d_i(use_d_i), .rs_e_i(rs_e_i),
    .fwd_e_o(fwd_e_o), .stall_fd_o(stall_fd_o), .bubble_e_o(bubble_e_o)
`ifdef FWD_HAZARD_PERF_EN
    , .perf_stall_o(perf_stall_o), .perf_fwd_o(perf_fwd_o)
`endif
  );

  typedef struct {
    string       nm;
    logic        hold, flush;
    logic [4:0]  rd;
    logic        wen;
    logic [1:0]  rdy;
    logic [4:0]  rs0, rs1;
    logic [1:0]  use_;
    logic [4:0]  re0, re1;
    logic [1:0]  f0, f1;
    logic        st, bu;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(string nm, logic h, logic fl, int rd, logic w, int rdy,
                              int a, int b, logic [1:0] u, int ea, int eb,
                              int f0, int f1, logic st, logic bu);
    vec_t v;
    v.nm = nm; v.hold = h; v.flush = fl; v.rd = 5'(rd); v.wen = w; v.rdy = 2'(rdy);
    v.rs0 = 5'(a); v.rs1 = 5'(b); v.use_ = u; v.re0 = 5'(ea); v.re1 = 5'(eb);
    v.f0 = 2'(f0); v.f1 = 2'(f1); v.st = st; v.bu = bu;
    return v;
  endfunction

  task automatic nops(int n);
    for (int i = 0; i < n; i++) tbl.push_back(mk("nop", 0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic drive(vec_t v);
    hold_i = v.hold; flush_e_i = v.flush; rd_d_i = v.rd; wen_d_i = v.wen; rdy_d_i = v.rdy;
    rs_d_i = {v.rs1, v.rs0}; use_d_i = v.use_; rs_e_i = {v.re1, v.re0};
  endtask

  task automatic check_out();
    vec_t e;
    if (exp_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard: no expected entry, got none, required one");
      return;
    end
    e = exp_q.pop_front();
    cmp({e.nm, " fwd0"},   32'(fwd_e_o[SEL_W-1:0]),       32'(e.f0));
    cmp({e.nm, " fwd1"},   32'(fwd_e_o[2*SEL_W-1:SEL_W]), 32'(e.f1));
    cmp({e.nm, " stall"},  32'(stall_fd_o),               32'(e.st));
    cmp({e.nm, " bubble"}, 32'(bubble_e_o),               32'(e.bu));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    // Test 1: add x5 then add x6,x5,x5
    tbl.push_back(mk("t1a", 0, 0, 5, 1, 1, 1, 2, 2'b11, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("t1b", 0, 0, 6, 1, 1, 5, 5, 2'b11, 1, 2, 0, 0, 0, 0));
    tbl.push_back(mk("t1c", 0, 0, 0, 0, 1, 0, 0, 2'b00, 5, 5, 1, 1, 0, 0));
    nops(4);
    // Test 2: lw x7 then add x8,x7,x0
    tbl.push_back(mk("t2a", 0, 0, 7, 1, 2, 1, 0, 2'b01, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("t2b", 0, 0, 8, 1, 1, 7, 0, 2'b11, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk("t2c", 0, 0, 8, 1, 1, 7, 0, 2'b11, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("t2d", 0, 0, 0, 0, 1, 0, 0, 2'b00, 7, 0, 2, 0, 0, 0));
    nops(4);
    // Test 3a: rdy=3 producer, dependent next
    tbl.push_back(mk("t3a0", 0, 0, 9, 1, 3, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("t3a1", 0, 0, 11, 1, 1, 9, 9, 2'b11, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk("t3a2", 0, 0, 11, 1, 1, 9, 9, 2'b11, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk("t3a3", 0, 0, 11, 1, 1, 9, 9, 2'b11, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("t3a4", 0, 0, 0, 0, 1, 0, 0, 2'b00, 9, 9, 3, 3, 0, 0));
    nops(4);
    // Test 3b: one independent instruction in between
    tbl.push_back(mk("t3b0", 0, 0, 9, 1, 3, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("t3b1", 0, 0, 12, 1, 1, 1, 2, 2'b11, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("t3b2", 0, 0, 11, 1, 1, 9, 9, 2'b11, 1, 2, 0, 0, 1, 1));
    tbl.push_back(mk("t3b3", 0, 0, 11, 1, 1, 9, 9, 2'b11, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("t3b4", 0, 0, 0, 0, 1, 0, 0, 2'b00, 9, 9, 3, 3, 0, 0));
    nops(4);
    // Test 4: writes to x0 never match
    tbl.push_back(mk("t4a", 0, 0, 0, 1, 3, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("t4b", 0, 0, 13, 1, 1, 0, 0, 2'b11, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("t4c", 0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    nops(4);
    // Test 5: two writers of x10 at MEM and WB, youngest wins
    tbl.push_back(mk("t5a", 0, 0, 10, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("t5b", 0, 0, 10, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("t5c", 0, 0, 14, 1, 1, 10, 3, 2'b11, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("t5d", 0, 0, 0, 0, 1, 0, 0, 2'b00, 10, 3, 1, 0, 0, 0));
    nops(4);
    // Test 6: load-use under hold, then flush with the hazard
    tbl.push_back(mk("t6a", 0, 0, 7, 1, 2, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk("t6hold", 1, 0, 15, 1, 1, 7, 7, 2'b11, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk("t6flush", 0, 1, 15, 1, 1, 7, 7, 2'b11, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk("t6go", 0, 0, 15, 1, 1, 7, 7, 2'b11, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("t6ex", 0, 0, 0, 0, 1, 0, 0, 2'b00, 7, 7, 2, 2, 0, 0));
    // Setup for reset mid-stall: add x5, then lw x7,0(x5)
    tbl.push_back(mk("t7a", 0, 0, 5, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("t7b", 0, 0, 7, 1, 2, 5, 0, 2'b01, 0, 0, 0, 0, 0, 0));

    reset = 1'b1;
    drive(mk("rst", 0, 1, 0, 0, 1, 5, 5, 2'b11, 5, 5, 0, 0, 0, 0));
    #12;
    cmp("reset stall",  32'(stall_fd_o), 32'd0);
    cmp("reset bubble", 32'(bubble_e_o), 32'd0);
    cmp("reset fwd",    32'(fwd_e_o),    32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      exp_q.push_back(tbl[i]);
      @(negedge clk);
      check_out();
      @(posedge clk); #1;
    end

    // add x8,x7 in decode while lw in EX (stall) and lw reads x5 from MEM (fwd=1)
    rv = mk("t7c", 0, 0, 8, 1, 1, 7, 0, 2'b11, 5, 0, 1, 0, 1, 1);
    drive(rv);
    exp_q.push_back(rv);
    #2;
    check_out();
    #1 reset = 1'b1;
    #1;
    cmp("midrst stall",  32'(stall_fd_o), 32'd0);
    cmp("midrst bubble", 32'(bubble_e_o), 32'd0);
    cmp("midrst fwd",    32'(fwd_e_o),    32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    cmp("postrst stall", 32'(stall_fd_o),       32'd0);
    cmp("postrst fwd0",  32'(fwd_e_o[SEL_W-1:0]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
